// File: rtl/mtr_drv_if.sv
// Speed-command / bridge-drive bundle between heading controller and mtr_drv.
// MTR_BRAKE_EN adds the brake request line.
interface mtr_drv_if;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               lftPWM1;
  logic               lftPWM2;
  logic               rghtPWM1;
  logic               rghtPWM2;
  logic               period_strt;
`ifdef MTR_BRAKE_EN
  logic               brake;
`endif

  modport master (
`ifdef MTR_BRAKE_EN
    output brake,
`endif
    output lft_spd,
    output rght_spd,
    input  lftPWM1,
    input  lftPWM2,
    input  rghtPWM1,
    input  rghtPWM2,
    input  period_strt
  );

  modport slave (
`ifdef MTR_BRAKE_EN
    input  brake,
`endif
    input  lft_spd,
    input  rght_spd,
    output lftPWM1,
    output lftPWM2,
    output rghtPWM1,
    output rghtPWM2,
    output period_strt
  );
endinterface

// File: rtl/mtr_drv.sv
// Dual H-bridge PWM driver: period-aligned duty latch plus dead-time.
// Optional MTR_BRAKE_EN forces both channels to low-side-on.
module mtr_drv #(
  parameter int DEAD = 32
) (
  input logic       clk,
  input logic       rst,
  mtr_drv_if.slave  bus
);

  localparam logic [7:0]         DEAD8 = 8'(DEAD);
  localparam logic signed [11:0] SMAX  = 12'sd1023;
  localparam logic signed [11:0] SMIN  = -12'sd1024;

  // Saturate to +-1024 range, then offset by 1024 (flip of bit 10).
  function automatic logic [10:0] to_duty(input logic signed [11:0] s);
    if (s > SMAX) return 11'h7ff;
    if (s < SMIN) return 11'h000;
    return s[10:0] ^ 11'h400;
  endfunction

  logic [10:0]       cnt_q, cnt_d;
  logic              ps_q, ps_d;
  logic [1:0][10:0]  duty_q, duty_d;
  logic [1:0]        prev_q;
  logic [1:0]        raw;
  logic [1:0][7:0]   dead_q, dead_d;
  logic [1:0]        p1_q, p1_d;
  logic [1:0]        p2_q, p2_d;
  logic [1:0][11:0]  spd;
  logic              brk;

  assign spd[0] = bus.lft_spd;
  assign spd[1] = bus.rght_spd;

`ifdef MTR_BRAKE_EN
  assign brk = bus.brake;
`else
  assign brk = 1'b0;
`endif

  // Outputs follow the next-state dead counter so the gap is exactly DEAD.
  always_comb begin
    cnt_d  = cnt_q + 11'd1;
    ps_d   = (cnt_q == 11'd0);
    duty_d = duty_q;
    raw    = '0;
    dead_d = dead_q;
    p1_d   = '0;
    p2_d   = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (cnt_q == 11'h7ff)
        duty_d[ch] = to_duty(signed'(spd[ch]));
      raw[ch] = (cnt_q < duty_q[ch]) & ~brk;
      if (raw[ch] != prev_q[ch])
        dead_d[ch] = DEAD8;
      else if (dead_q[ch] != 8'd0)
        dead_d[ch] = dead_q[ch] - 8'd1;
      p1_d[ch] = (dead_d[ch] == 8'd0) & raw[ch];
      p2_d[ch] = (dead_d[ch] == 8'd0) & ~raw[ch];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      ps_q   <= 1'b0;
      duty_q <= {2{11'd1024}};
      prev_q <= '0;
      dead_q <= {2{DEAD8}};
      p1_q   <= '0;
      p2_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ps_q   <= ps_d;
      duty_q <= duty_d;
      prev_q <= raw;
      dead_q <= dead_d;
      p1_q   <= p1_d;
      p2_q   <= p2_d;
    end
  end

  assign bus.lftPWM1     = p1_q[0];
  assign bus.lftPWM2     = p2_q[0];
  assign bus.rghtPWM1    = p1_q[1];
  assign bus.rghtPWM2    = p2_q[1];
  assign bus.period_strt = ps_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: per-period high-time scoreboard, reset and overlap checks.
// Brake window exercised only when MTR_BRAKE_EN is defined.
module tb_mtr_drv;

  localparam int D = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mtr_drv_if bus ();

  mtr_drv #(.DEAD(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string tag;
    int    l1;
    int    l2;
    int    r1;
    int    r2;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected per-period high times from a latched duty value.
  function automatic int hi1(input int d);
    if (d == 0)    return 0;
    if (d == 2047) return 2047 - D;
    return d - D;
  endfunction

  function automatic int hi2(input int d);
    if (d == 0)    return 2048;
    if (d == 2047) return 0;
    return 2048 - d - D;
  endfunction

  task automatic push(input string tag, input int dl, input int dr);
    exp_t x;
    x.tag = tag;
    x.l1  = hi1(dl);
    x.l2  = hi2(dl);
    x.r1  = hi1(dr);
    x.r2  = hi2(dr);
    sb.push_back(x);
  endtask

  function automatic logic [4:0] outs();
    return {bus.lftPWM1, bus.lftPWM2, bus.rghtPWM1,
            bus.rghtPWM2, bus.period_strt};
  endfunction

  // Monitor: windows run from one period_strt to the next.
  int c1l, c2l, c1r, c2r, gap;
  bit started, gap_ok;

  always @(negedge clk) begin
    chk("ovl_l", int'(bus.lftPWM1 & bus.lftPWM2), 0);
    chk("ovl_r", int'(bus.rghtPWM1 & bus.rghtPWM2), 0);
    if (rst) begin
      started = 1'b0;
      gap_ok  = 1'b0;
      gap     = 0;
    end else begin
      gap++;
      if (bus.period_strt) begin
        if (gap_ok) chk("ps_gap", gap, 2048);
        gap_ok = 1'b1;
        gap    = 0;
        if (started && sb.size() > 0) begin
          e = sb.pop_front();
          chk({e.tag, "_l1"}, c1l, e.l1);
          chk({e.tag, "_l2"}, c2l, e.l2);
          chk({e.tag, "_r1"}, c1r, e.r1);
          chk({e.tag, "_r2"}, c2r, e.r2);
        end
        c1l = 0; c2l = 0; c1r = 0; c2r = 0;
        started = 1'b1;
      end
      if (started) begin
        c1l += int'(bus.lftPWM1);
        c2l += int'(bus.lftPWM2);
        c1r += int'(bus.rghtPWM1);
        c2r += int'(bus.rghtPWM2);
      end
    end
  end

  task automatic wait_ps();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.period_strt;
    end
    chk("ps_seen", int'(seen), 1);
    #1;
  endtask

  // Called right after rst drops on a negedge; sample k shows cnt==k.
  task automatic post_rst(input string tag);
    int lows;
    lows = 0;
    for (int k = 1; k <= D; k++) begin
      @(negedge clk);
      if ({bus.lftPWM1, bus.lftPWM2, bus.rghtPWM1, bus.rghtPWM2} == 4'b0)
        lows++;
      if (k == 1) chk({tag, "_ps1"}, int'(bus.period_strt), 1);
    end
    chk({tag, "_dead"}, lows, D);
    @(negedge clk);
    chk({tag, "_onl"}, int'(bus.lftPWM1), 1);
    chk({tag, "_onr"}, int'(bus.rghtPWM1), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lft_spd  = '0;
    bus.rght_spd = '0;
`ifdef MTR_BRAKE_EN
    bus.brake    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_out", int'(outs()), 0);
    rst = 1'b0;
    post_rst("rel");

    wait_ps();
    push("p50", 1024, 1024);
    bus.lft_spd = 12'sd512;

    wait_ps();
    push("p512", 1536, 1024);
    bus.lft_spd  = -12'sd2048;
    bus.rght_spd = 12'sd2047;

    wait_ps();
    push("sat", 0, 2047);
    bus.lft_spd  = '0;
    bus.rght_spd = '0;

    wait_ps();
    push("mid", 1024, 1024);
    repeat (499) @(negedge clk);
    bus.lft_spd = -12'sd256;

    wait_ps();
    push("m256", 768, 1024);

`ifdef MTR_BRAKE_EN
    bus.brake = 1'b1;
    wait_ps();
    push("brk", 0, 0);
    wait_ps();
    bus.brake = 1'b0;
    wait_ps();
`endif

    wait_ps();
    repeat (1499) @(negedge clk);
    chk("pre_rst_p2", int'(bus.lftPWM2), 1);
    #1 rst = 1'b1;
    #1 chk("rst_async", int'(outs()), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    post_rst("rel2");

    wait_ps();
    push("post", 768, 1024);
    wait_ps();
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
